// File: rtl/cacheline_adaptor_pkg.sv
// rtl/cacheline_adaptor_pkg.sv - shared types and constants for the L2 line to burst adaptor
package cacheline_adaptor_pkg;

  localparam int LINE_WIDTH       = 256;
  localparam int BEAT_WIDTH       = 64;
  localparam int BEATS            = LINE_WIDTH / BEAT_WIDTH;
  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR,
    RESP,
    DONE
  } adaptor_state_t;

  typedef logic [1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = 2'(BEATS - 1);
  localparam logic [31:0] LINE_ADDR_MASK = ~32'((1 << LINE_OFFSET_BITS) - 1);

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & LINE_ADDR_MASK;
  endfunction

endpackage

// File: rtl/cacheline_adaptor_buffer.sv
// rtl/cacheline_adaptor_buffer.sv - 256-bit line register with beat-wide write and read ports
module line_beat_buffer
  import cacheline_adaptor_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [255:0] load_data,
  input  logic         wr_en,
  input  logic [1:0]   wr_idx,
  input  logic [63:0]  wr_data,
  input  logic [1:0]   rd_idx,
  output logic [63:0]  rd_data,
  output logic [255:0] line
);

  logic [LINE_WIDTH-1:0] line_q;
  logic [LINE_WIDTH-1:0] line_d;

  // A full-line load (write request capture) takes priority over beat assembly.
  always_comb begin
    line_d = line_q;
    if (load) begin
      line_d = load_data;
    end else if (wr_en) begin
      line_d[int'(wr_idx) * BEAT_WIDTH +: BEAT_WIDTH] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign rd_data = line_q[int'(rd_idx) * BEAT_WIDTH +: BEAT_WIDTH];
  assign line    = line_q;

endmodule

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - converts one 256-bit line request into a 4-beat 64-bit memory burst
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  line_addr,
  input  logic         line_read,
  input  logic         line_write,
  input  logic [255:0] line_wdata,
  output logic [255:0] line_rdata,
  output logic         line_resp,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  adaptor_state_t state_q, state_d;
  beat_idx_t      cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;

  logic           buf_load;
  logic           beat_store;
  logic [63:0]    buf_rd_data;
  logic [255:0]   buf_line;

  assign buf_load   = (state_q == IDLE) && line_write;
  // Beats for other lines share the return bus and must not land in this buffer.
  assign beat_store = (state_q == RD_WAIT) && bmem_rvalid && (bmem_raddr == addr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (line_write) begin
          addr_d  = line_align(line_addr);
          cnt_d   = '0;
          state_d = WR;
        end else if (line_read) begin
          addr_d  = line_align(line_addr);
          cnt_d   = '0;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (beat_store) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
          end
        end
      end
      WR: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  line_beat_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_data (line_wdata),
    .wr_en     (beat_store),
    .wr_idx    (cnt_q),
    .wr_data   (bmem_rdata),
    .rd_idx    (cnt_q),
    .rd_data   (buf_rd_data),
    .line      (buf_line)
  );

  assign line_resp  = (state_q == RESP);
  assign line_rdata = buf_line;
  assign bmem_read  = (state_q == RD_REQ);
  assign bmem_write = (state_q == WR);
  assign bmem_addr  = addr_q;
  assign bmem_wdata = buf_rd_data;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_addr;
  logic         line_read;
  logic         line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk         (clk),
    .rst         (rst),
    .line_addr   (line_addr),
    .line_read   (line_read),
    .line_write  (line_write),
    .line_wdata  (line_wdata),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  typedef struct {
    logic         wr;
    logic         rd;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [5:0]   ready_pat;
    int           exp_lat;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic [63:0]  wq[$];
  logic [255:0] lq[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_bus();
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
  endtask

  // Drives one request, models the memory side, and scores beats and the response.
  task automatic run_txn(input vec_t v);
    logic [31:0] exp_addr;
    int          acc;
    int          resp_n;
    int          beat_i;
    logic        accepted;
    logic        done;
    exp_addr = v.addr & 32'hFFFF_FFE0;
    line_addr  = v.addr;
    line_write = v.wr;
    line_read  = v.rd;
    line_wdata = v.wr ? v.data : ~v.data;
    if (v.wr) begin
      for (int i = 0; i < 4; i++) wq.push_back(v.data[i*64 +: 64]);
    end else begin
      lq.push_back(v.data);
    end
    step();
    acc = 0; resp_n = 0; beat_i = 0; accepted = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      bmem_ready  = v.ready_pat[k % 6];
      bmem_rvalid = 1'b0;
      if (accepted && beat_i < 4) begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = exp_addr;
        bmem_rdata  = v.data[beat_i*64 +: 64];
        beat_i++;
      end
      if (bmem_read || bmem_write) chk("bmem_addr", bmem_addr, exp_addr);
      if (v.wr) chk("no_read_on_write", bmem_read, 1'b0);
      if (bmem_read && bmem_ready) begin
        acc++;
        accepted = 1'b1;
      end
      if (bmem_write && bmem_ready) begin
        if (wq.size() == 0) chk("extra_wbeat", 1'b1, 1'b0);
        else chk("wbeat", bmem_wdata, wq.pop_front());
      end
      if (line_resp) begin
        resp_n++;
        done = 1'b1;
        chk("latency", k, v.exp_lat);
        chk("resp_bus_idle", {bmem_read, bmem_write}, 2'b00);
        if (!v.wr && lq.size() != 0) chk("line_rdata", line_rdata, lq.pop_front());
      end
      step();
    end
    chk("resp_seen", resp_n, 1);
    if (!v.wr) chk("cmd_count", acc, 1);
    chk("wq_drained", wq.size(), 0);
    wq.delete();
    lq.delete();
    quiet_bus();
    // Request still held during the dead cycle: nothing may start.
    chk("done_quiet", {line_resp, bmem_read, bmem_write}, 3'b000);
    line_read  = 1'b0;
    line_write = 1'b0;
    step();
    chk("idle_quiet", {line_resp, bmem_read, bmem_write}, 3'b000);
  endtask

  vec_t vecs[5];

  logic [255:0] s_line;
  logic [31:0]  b_addr[6];
  logic [63:0]  b_data[6];
  logic         b_vld[6];

  initial begin
    vecs[0] = '{wr: 1'b0, rd: 1'b1, addr: 32'h0000_1244,
                data: {64'h3, 64'h2, 64'h1, 64'h0}, ready_pat: 6'b111111, exp_lat: 5};
    vecs[1] = '{wr: 1'b1, rd: 1'b0, addr: 32'h0000_2008,
                data: {64'hD, 64'hC, 64'hB, 64'hA}, ready_pat: 6'b101101, exp_lat: 6};
    vecs[2] = '{wr: 1'b1, rd: 1'b1, addr: 32'h0000_3000,
                data: {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                       64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001},
                ready_pat: 6'b111111, exp_lat: 4};
    vecs[3] = '{wr: 1'b0, rd: 1'b1, addr: 32'hFFFF_FFFF,
                data: {64'hFEED_FACE_0000_0003, 64'hCAFE_BABE_0000_0002,
                       64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF},
                ready_pat: 6'b111110, exp_lat: 6};
    vecs[4] = '{wr: 1'b1, rd: 1'b0, addr: 32'h0000_0040,
                data: {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
                       64'hFFFF_FFFF_FFFF_FFFF, 64'h0},
                ready_pat: 6'b111111, exp_lat: 4};

    rst = 1'b1;
    line_addr = '0; line_read = 1'b0; line_write = 1'b0; line_wdata = '0;
    quiet_bus();
    step();
    step();
    chk("rst_ctrl", {line_resp, bmem_read, bmem_write}, 3'b000);
    chk("rst_addr", bmem_addr, 32'h0);
    chk("rst_wdata", bmem_wdata, 64'h0);
    chk("rst_rdata", line_rdata, 256'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Command stall in RD_REQ, stray beats before acceptance, then a foreign-address beat mid-burst.
    s_line = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
              64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    line_addr = 32'h0000_1240;
    line_read = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h0000_1240;
      bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
      chk("stall_read_held", bmem_read, 1'b1);
      chk("stall_addr", bmem_addr, 32'h0000_1240);
      step();
    end
    bmem_rvalid = 1'b0;
    bmem_ready  = 1'b1;
    chk("stall_read_held", bmem_read, 1'b1);
    step();
    bmem_ready = 1'b0;
    chk("cmd_once", bmem_read, 1'b0);
    b_vld[0] = 1'b1; b_addr[0] = 32'h0000_1240; b_data[0] = s_line[63:0];
    b_vld[1] = 1'b1; b_addr[1] = 32'h0000_2000; b_data[1] = 64'hBAD1_BAD1_BAD1_BAD1;
    b_vld[2] = 1'b0; b_addr[2] = 32'h0000_1240; b_data[2] = 64'hBAD2_BAD2_BAD2_BAD2;
    b_vld[3] = 1'b1; b_addr[3] = 32'h0000_1240; b_data[3] = s_line[127:64];
    b_vld[4] = 1'b1; b_addr[4] = 32'h0000_1240; b_data[4] = s_line[191:128];
    b_vld[5] = 1'b1; b_addr[5] = 32'h0000_1240; b_data[5] = s_line[255:192];
    for (int i = 0; i < 6; i++) begin
      bmem_rvalid = b_vld[i];
      bmem_raddr  = b_addr[i];
      bmem_rdata  = b_data[i];
      step();
      if (i < 5) chk("no_early_resp", line_resp, 1'b0);
    end
    quiet_bus();
    chk("mismatch_resp", line_resp, 1'b1);
    chk("mismatch_rdata", line_rdata, s_line);
    step();
    chk("mismatch_done_quiet", {line_resp, bmem_read, bmem_write}, 3'b000);
    line_read = 1'b0;
    step();

    // Reset abandons a read after two beats.
    line_addr = 32'h0000_1240;
    line_read = 1'b1;
    step();
    bmem_ready = 1'b1;
    step();
    bmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h0000_1240;
      bmem_rdata  = 64'h0DD0_0000_0000_0000 | 64'(i);
      step();
    end
    rst = 1'b1;
    line_read = 1'b0;
    quiet_bus();
    step();
    chk("mid_rst_ctrl", {line_resp, bmem_read, bmem_write}, 3'b000);
    chk("mid_rst_addr", bmem_addr, 32'h0);
    chk("mid_rst_wdata", bmem_wdata, 64'h0);
    chk("mid_rst_rdata", line_rdata, 256'h0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h0000_1240;
      bmem_rdata  = 64'h0DD0_0000_0000_0002 + 64'(i);
      step();
      chk("stray_no_resp", line_resp, 1'b0);
    end
    quiet_bus();
    run_txn('{wr: 1'b0, rd: 1'b1, addr: 32'h0000_1240,
              data: {64'h5EED_0000_0000_0003, 64'h5EED_0000_0000_0002,
                     64'h5EED_0000_0000_0001, 64'h5EED_0000_0000_0000},
              ready_pat: 6'b111111, exp_lat: 5});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
Responder at the memory end of the arbiter's L2 line interface. Accepts one 256-bit cache-line read or write from the arbiter and converts it into a 4-beat, 64-bit burst transaction on the banked-memory interface. For reads, it reassembles the returned beats into a line; for writes, it serialises the line into beats. It then returns a single-cycle response to the arbiter.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BEAT_WIDTH, 64, memory burst beat width in bits.
- BEATS, LINE_WIDTH/BEAT_WIDTH = 4, beats per line. Derived; not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- line_addr  input  32  line request address from the arbiter; bits [4:0] ignored
- line_read  input  1  line read request; held until line_resp
- line_write  input  1  line write request; held until line_resp
- line_wdata  input  256  write line data
- line_rdata  output  256  read line data; valid while line_resp=1
- line_resp  output  1  one-cycle completion pulse
- bmem_addr  output  32  burst base address, 32-byte aligned
- bmem_read  output  1  burst read command
- bmem_write  output  1  burst write beat valid
- bmem_wdata  output  64  write beat data
- bmem_ready  input  1  memory accepts a command or write beat this cycle
- bmem_raddr  input  32  base address of the returning read beat
- bmem_rdata  input  64  read beat data
- bmem_rvalid  input  1  read beat valid

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high (rst).
- Reset values:
  - FSM returns to IDLE; beat counter = 0.
  - line_resp, bmem_read and bmem_write = 0.
  - bmem_addr, bmem_wdata, line_rdata and the line buffer = 0.
- Reset mid-operation: the transaction is abandoned and no line_resp is issued. Beats still in flight are discarded because the FSM is not in RD_WAIT.
- All outputs are driven from registers or decoded from state only. There is no combinational path from line_* inputs to bmem_* outputs.
- IDLE:
  - line_write=1: latch addr {line_addr[31:5],5'b0} and line_wdata; counter=0; go to WR.
  - line_write=0 and line_read=1: latch addr; counter=0; go to RD_REQ.
  - Both asserted together: write wins.
- RD_REQ:
  - bmem_read=1, bmem_addr=latched addr.
  - When bmem_ready=1 the command is accepted; go to RD_WAIT. Otherwise hold the command.
- RD_WAIT:
  - On bmem_rvalid=1 with bmem_raddr == latched addr: buffer[counter*64 +: 64] = bmem_rdata, then counter++.
  - When the beat with counter==3 is stored, go to RESP.
  - rvalid with a mismatched raddr is ignored.
  - Beats need not be consecutive; gaps are allowed.
- WR:
  - bmem_write=1, bmem_addr=latched addr, bmem_wdata=wbuf[counter*64 +: 64].
  - Beat 0 is bits [63:0].
  - The counter advances only when bmem_ready=1. If ready=0, the same beat is held.
  - When beat 3 is accepted, go to RESP.
- RESP:
  - line_resp=1 for exactly one cycle.
  - line_rdata = line buffer for reads; don't-care for writes (driven from buffer).
  - Go to DONE.
- DONE:
  - One dead cycle in which line_read/line_write are ignored. This covers the arbiter's mux_sel update latency.
  - Go to IDLE.
- Latency:
  - Minimum read: 1 (IDLE) + 1 (RD_REQ) + 4 beats + 1 (RESP) cycles.
  - Minimum write: 1 + 4 + 1 cycles.
  - Back-to-back requests are separated by DONE.
- bmem_rvalid outside RD_WAIT is ignored in every state.
- Counter: 2 bits, wraps to 0 on transaction accept.
- Requests that drop before line_resp are a protocol violation. The adaptor completes the latched transaction anyway.

Decomposition:
- Shared package cacheline_adaptor_pkg holds:
  - typedef enum logic [2:0] adaptor_state_t {IDLE, RD_REQ, RD_WAIT, WR, RESP, DONE}.
  - Localparams LINE_OFFSET_BITS=5 and BEATS=4.
  - The beat-index typedef.
- One natural sub-module: line_beat_buffer. It is a 256-bit register with a 64-bit indexed write port (read assembly) and a 64-bit indexed read port (write serialisation), cleared on rst.
- The FSM and counter live in the top module.

Test Plan:
- Read with ready=1 throughout, rvalid on 4 consecutive cycles, raddr=0x00001240, beats 0x0..0x3 -> line_rdata = {64'h3,64'h2,64'h1,64'h0}, line_resp high exactly 1 cycle, bmem_addr=0x00001240. Request line_addr=0x00001244 to confirm the low 5 bits are masked.
- Write line_wdata = {64'hD,64'hC,64'hB,64'hA}, bmem_ready toggling 1,0,1,1,0,1 -> bmem_wdata sequence A,B,B,C,D,D with 4 accepted beats in order, then a single line_resp, and bmem_write=0 in RESP.
- RD_REQ with bmem_ready=0 for 5 cycles -> bmem_read held high with a stable address; exactly one command accepted.
- During RD_WAIT, inject rvalid with raddr=0x00002000 while the latched addr is 0x00001240 -> the beat is ignored, the counter is unchanged, and the line completes only after 4 matching beats.
- line_read and line_write asserted together -> write burst issued, no bmem_read. Request held through DONE -> no new transaction starts until IDLE.
- Assert rst during RD_WAIT after 2 beats -> next cycle all outputs are 0 and the state is IDLE. A following read with fresh beats returns only the new data.
